mem_dcache_ctrl: RTL

//  - MEM-stage data cache and controller: the producer of readData/hit consumed by the MEM/WB register.
//  - Direct-mapped, one 32-bit word per line, write-through, no-write-allocate.
//  - A miss or any store holds hit=0 and the pipeline stalls. The controller then handshakes with backing memory.
//  - hit=1 tells MEM/WB to capture on the following negedge clk.

---
 rtl/mem_dcache_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mem_dcache_ctrl.sv
// MEM-stage direct-mapped write-through data cache with a registered backing-memory handshake.
// Load hit 0 cycles; miss/store = issue + memory wait + 1 RESP cycle. Optional stats via DCACHE_STATS_EN.
module mem_dcache_ctrl #(
  parameter int INDEX_BITS = 4,
  localparam int TAG_BITS = 32 - INDEX_BITS - 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        hit,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int LINES = 2 ** INDEX_BITS;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} stateE;

  stateE curState, nextState;

  logic [LINES-1:0]    lineValid;
  logic [TAG_BITS-1:0] lineTag  [LINES];
  logic [31:0]         lineData [LINES];
  logic [31:0]         respData;

  logic [INDEX_BITS-1:0] idx, reqIdx;
  logic [TAG_BITS-1:0]   tagIn, reqTag;
  logic [31:0]           wordAddr;
  logic                  lookupHit;
  logic                  unusedAddrBits;

  assign idx            = addr[INDEX_BITS+1:2];
  assign tagIn          = addr[31:INDEX_BITS+2];
  assign wordAddr       = {addr[31:2], 2'b00};
  assign unusedAddrBits = ^addr[1:0];
  // The in-flight line is addressed from the registered request, not the live bus.
  assign reqIdx         = mem_addr[INDEX_BITS+1:2];
  assign reqTag         = mem_addr[31:INDEX_BITS+2];
  assign lookupHit      = lineValid[idx] && (lineTag[idx] == tagIn);

  always_comb begin
    nextState = curState;
    hit       = 1'b0;
    readData  = 32'h0;
    case (curState)
      IDLE: begin
        if (MemWrite) begin
          nextState = WRITE;
        end else if (MemRead) begin
          if (lookupHit) begin
            hit      = 1'b1;
            readData = lineData[idx];
          end else begin
            nextState = FILL;
          end
        end else begin
          hit = 1'b1;
        end
      end
      FILL:    if (mem_ack) nextState = RESP;
      WRITE:   if (mem_ack) nextState = RESP;
      RESP: begin
        hit       = 1'b1;
        readData  = respData;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      curState  <= IDLE;
      lineValid <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      respData  <= 32'h0;
    end else begin
      curState <= nextState;
      case (curState)
        IDLE: begin
          if (MemWrite) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= wordAddr;
            mem_wdata <= writeData;
          end else if (MemRead && !lookupHit) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= wordAddr;
          end
        end
        FILL: begin
          if (mem_ack) begin
            mem_req           <= 1'b0;
            lineValid[reqIdx] <= 1'b1;
            respData          <= mem_rdata;
          end
        end
        WRITE: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            respData <= 32'h0;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag/data arrays need no reset: valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (curState == FILL && mem_ack) begin
      lineTag[reqIdx]  <= reqTag;
      lineData[reqIdx] <= mem_rdata;
    end else if (curState == WRITE && mem_ack && lineValid[reqIdx] && lineTag[reqIdx] == reqTag) begin
      lineData[reqIdx] <= mem_wdata;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hitCnt, missCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hitCnt  <= 32'h0;
      missCnt <= 32'h0;
    end else if (curState == IDLE && !MemWrite && MemRead) begin
      if (lookupHit) hitCnt  <= hitCnt + 32'd1;
      else           missCnt <= missCnt + 32'd1;
    end
  end

  assign hit_count  = hitCnt;
  assign miss_count = missCnt;
`else
  assign hit_count  = 32'h0;
  assign miss_count = 32'h0;
`endif

endmodule
